// File: rtl/aes_axis_pkg.sv
// Shared constants and helpers for the AES-CTR AXI4-Stream datapath.
package aes_axis_pkg;

   localparam int AES_BLK_W   = 128;
   localparam int AXIS_HOST_W = 32;
   localparam int AES_KEEP_W  = 16;

   // True when k is of the form 2^n-1 with n>=1 (bytes contiguous from bit 0).
   // Narrower keep vectors are zero-extended by the caller; that preserves the property.
   function automatic logic keep_contig(input logic [AES_KEEP_W-1:0] k);
      logic [AES_KEEP_W-1:0] kp1;
      kp1 = k + AES_KEEP_W'(1);
      return (k != '0) && ((k & kp1) == '0);
   endfunction

endpackage

// File: rtl/axis_pack_32to128.sv
// 32->128 AXI4-Stream packer. Words accumulate into lanes; a beat is emitted
// after LANES words or on s_tlast, with unused lanes zeroed in data and keep.
// Optional: define AXIS_PACK_ERR_EN to enable the sticky err_keep protocol check.
module axis_pack_32to128
   import aes_axis_pkg::*;
#(
   parameter int IN_W  = AXIS_HOST_W,
   parameter int OUT_W = AES_BLK_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_W-1:0]      s_tdata,
   input  logic [IN_W/8-1:0]    s_tkeep,
   input  logic                 s_tlast,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   output logic [OUT_W-1:0]     m_tdata,
   output logic [OUT_W/8-1:0]   m_tkeep,
   output logic                 m_tlast,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic                 err_keep
);

   localparam int LANES = OUT_W / IN_W;
   localparam int KB    = IN_W / 8;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   typedef logic [LANES-1:0][IN_W-1:0] lane_data_t;
   typedef logic [LANES-1:0][KB-1:0]   lane_keep_t;

   lane_data_t      acc_data_q, acc_data_d;
   lane_keep_t      acc_keep_q, acc_keep_d;
   logic [LW-1:0]   lane_q, lane_d;
   lane_data_t      m_data_q, m_data_d;
   lane_keep_t      m_keep_q, m_keep_d;
   logic            m_last_q, m_last_d;
   logic            m_valid_q, m_valid_d;
   logic            xfer;
   lane_data_t      merged_data;
   lane_keep_t      merged_keep;

   // Ready depends only on the output register and downstream ready.
   assign s_tready = !m_valid_q || m_tready;
   assign xfer     = s_tvalid && s_tready;

   assign m_tdata  = m_data_q;
   assign m_tkeep  = m_keep_q;
   assign m_tlast  = m_last_q;
   assign m_tvalid = m_valid_q;

   // Next-state: accumulate a word, or close the beat into the output stage.
   always_comb begin
      acc_data_d  = acc_data_q;
      acc_keep_d  = acc_keep_q;
      lane_d      = lane_q;
      m_data_d    = m_data_q;
      m_keep_d    = m_keep_q;
      m_last_d    = m_last_q;
      m_valid_d   = m_valid_q;
      merged_data = acc_data_q;
      merged_keep = acc_keep_q;
      merged_data[lane_q] = s_tdata;
      merged_keep[lane_q] = s_tkeep;

      // Drain first; a beat completing in the same cycle overrides it.
      if (m_valid_q && m_tready) m_valid_d = 1'b0;

      if (xfer) begin
         if (lane_q == LAST_LANE || s_tlast) begin
            // Lanes above lane_q are still zero because acc is cleared per beat.
            m_data_d   = merged_data;
            m_keep_d   = merged_keep;
            m_last_d   = s_tlast;
            m_valid_d  = 1'b1;
            acc_data_d = '0;
            acc_keep_d = '0;
            lane_d     = '0;
         end else begin
            acc_data_d = merged_data;
            acc_keep_d = merged_keep;
            lane_d     = lane_q + LW'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_data_q <= '0;
         acc_keep_q <= '0;
         lane_q     <= '0;
         m_data_q   <= '0;
         m_keep_q   <= '0;
         m_last_q   <= 1'b0;
         m_valid_q  <= 1'b0;
      end else begin
         acc_data_q <= acc_data_d;
         acc_keep_q <= acc_keep_d;
         lane_q     <= lane_d;
         m_data_q   <= m_data_d;
         m_keep_q   <= m_keep_d;
         m_last_q   <= m_last_d;
         m_valid_q  <= m_valid_d;
      end
   end

`ifdef AXIS_PACK_ERR_EN
   logic err_q, err_d;

   // Flag non-contiguous keep, or partial keep on a non-last word; sticky until reset.
   always_comb begin
      err_d = err_q;
      if (xfer && (!keep_contig(AES_KEEP_W'(s_tkeep)) || (!s_tlast && s_tkeep != '1)))
         err_d = 1'b1;
   end

   // Sticky error register.
   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err_keep = err_q;
`else
   assign err_keep = 1'b0;
`endif

endmodule
